rr_n_to_one_mux: RTL and testbench
==================================

Name: rr_n_to_one_mux

Overview:
- Parametrised N:1 data multiplexer with valid/ready handshakes on every input channel and on the output.
- Two select modes: round-robin arbitration across requesting channels, or fixed select driven by a `sel` port.
- One registered output stage gives 1-cycle latency and full 1-transfer/cycle throughput.
- Sits between multiple producer channels and a single shared consumer datapath; generalises the basic 2:1 select.

Parameters:
- WIDTH, 8: data bits per channel.
- N, 4: number of input channels; N >= 2.
- SELW, clog2(N) = 2: width of `sel` and `out_ch`.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel request
- in_ready  output  N  per-channel accept; one-hot or zero
- mode  input  1  0 = round-robin, 1 = fixed select
- sel  input  SELW  channel index used when mode = 1
- out_data  output  WIDTH  registered selected data
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts
- out_ch  output  SELW  source channel index of out_data

Behaviour:
- **Reset:** reset is asynchronous; asserting reset_n low clears state immediately.
  - out_valid = 0, out_data = 0, out_ch = 0.
  - Round-robin pointer ptr = N-1, so the first RR grant goes to channel 0.
- **Load condition:** `load_en = !out_valid || out_ready`. The output register may take a new word only when load_en is 1.
- **Grant (combinational):**
  - Mode 0: first i with in_valid[i] = 1, searching circularly from ptr+1 through ptr (wrap N-1 -> 0).
  - Mode 1: grant = sel, only if sel < N and in_valid[sel] = 1.
  - If no grant exists, there is no accept.
- **in_ready:** `in_ready[g] = load_en && grant_exists`; all other bits are 0.
  - in_ready may depend combinationally on out_ready.
  - in_ready never depends on in_valid of the same channel beyond the grant search.
- **Accept (in_valid[g] && in_ready[g]), at the clock edge:**
  - out_data <= in_data[g], out_ch <= g, out_valid <= 1.
  - In mode 0 only, ptr <= g. In mode 1, ptr is unchanged.
- **Drain without accept:** if out_valid && out_ready and no accept occurs, then out_valid <= 0. out_data and out_ch hold their last values.
- **Stall:** if out_valid && !out_ready, out_data, out_ch and out_valid hold, and in_ready = 0.
- **Latency and throughput:**
  - Input transfer at cycle t appears on out_data at t+1.
  - Back-to-back accept and drain in the same cycle sustains 1 word/cycle.
- **Mode or sel change:**
  - Takes effect on the next grant evaluation.
  - The word already held in the output register is unaffected.
  - Switching from mode 1 back to mode 0 resumes from the preserved ptr.
- **Boundary cases:**
  - Single requester: granted every cycle while load_en is 1 (no forced skip).
  - All N requesting in mode 0: grants cycle 0,1,...,N-1,0 with no starvation.
  - sel >= N (possible when N is not a power of 2): no grant, and in_ready = 0.
- **Reset mid-transfer:** the held word is discarded, and the upstream channel sees no further in_ready until reset deasserts.
- **Width rules:**
  - No arithmetic on data.
  - ptr + 1 wraps modulo N explicitly; do not rely on natural SELW overflow when N is not a power of 2.

Decomposition:
- **Shared package:** MODE_RR = 1'b0, MODE_FIXED = 1'b1.
- **Sub-module rr_priority_pick:**
  - Combinational circular priority search.
  - Inputs: req[N], ptr.
  - Outputs: grant index and grant_valid.
- **Top level holds:** mode mux, load_en, the output register and ptr.

Test Plan:
1. Reset: hold reset_n = 0 with all inputs active -> out_valid = 0, out_data = 0, out_ch = 0, in_ready = 0; release with only in_valid[2] = 1, data 0xA5 -> next cycle out_data = 0xA5, out_ch = 2.
2. RR fairness: N = 4, in_valid = 4'b1111, data 0x10..0x13, out_ready = 1 -> out_ch sequence 0,1,2,3,0,1, one word per cycle, no bubbles.
3. Backpressure: out_ready = 0 for 3 cycles with a word held -> out_data stable, in_ready = 0; raise out_ready -> held word drains and a new word loads in the same cycle.
4. Fixed mode: mode = 1, sel = 3, in_valid = 4'b1111 -> only in_ready[3] pulses and out_ch = 3 every cycle; then sel = 1 -> out_ch = 1 from the following transfer.
5. Mode switch: RR grants ch1 (ptr = 1), switch to mode 1 sel = 0 for 2 transfers, back to mode 0 with all valid -> next grant is ch2.
6. Async reset mid-stream: drop reset_n between clock edges while out_valid = 1 -> out_valid = 0 immediately; after release, first RR grant is channel 0.

Source files
------------

// File: rtl/rr_n_to_one_mux_pkg.sv
// Shared definitions for the round-robin / fixed-select N:1 multiplexer.
// Holds mode encodings, default sizes and the circular index helper.
package rr_n_to_one_mux_pkg;

   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_N     = 4;

   // Circular successor of idx in 0..n-1; the wrap is explicit so that
   // channel counts that are not a power of two step correctly.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_n_to_one_mux_rr_priority_pick.sv
// Combinational circular priority search: first requester strictly after
// ptr, wrapping N-1 -> 0, ending with ptr itself.
module rr_priority_pick
   import rr_n_to_one_mux_pkg::*;
#(
   parameter int N    = DEF_N,
   parameter int SELW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [SELW-1:0] grant,
   output logic            grant_valid
);

   int idx;

   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      idx         = int'(ptr);
      for (int k = 0; k < N; k++) begin
         idx = wrap_inc(idx, N);
         if (!grant_valid && req[idx]) begin
            grant       = SELW'(idx);
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_n_to_one_mux.sv
// N:1 data multiplexer with per-channel valid/ready inputs, round-robin or
// fixed channel selection, and a single registered output stage.
module rr_n_to_one_mux
   import rr_n_to_one_mux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N     = DEF_N,
   parameter int SELW  = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SELW-1:0]      out_ch
);

   // Handshake: a word moves on any rising edge where valid && ready are both
   // high on that interface. in_ready is high only on the granted channel, only
   // while the output register can load (empty, or draining this cycle) and
   // only outside reset; it never waits on the channel's own valid beyond the
   // grant search. out_valid stays high and out_data/out_ch stay stable until
   // out_ready is seen.

   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  rr_grant;
   logic             rr_valid;
   logic [SELW-1:0]  fix_grant;
   logic             fix_valid;
   logic [SELW-1:0]  grant;
   logic             grant_valid;
   logic             load_en;
   logic             accept;
   logic [WIDTH-1:0] grant_data;

   rr_priority_pick #(
      .N    (N),
      .SELW (SELW)
   ) u_pick (
      .req         (in_valid),
      .ptr         (ptr),
      .grant       (rr_grant),
      .grant_valid (rr_valid)
   );

   // Fixed select; an out-of-range sel matches no channel and grants nothing.
   always_comb begin
      fix_grant = '0;
      fix_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (int'(sel) == i && in_valid[i]) begin
            fix_grant = SELW'(i);
            fix_valid = 1'b1;
         end
      end
   end

   always_comb begin
      if (mode == MODE_FIXED) begin
         grant       = fix_grant;
         grant_valid = fix_valid;
      end else begin
         grant       = rr_grant;
         grant_valid = rr_valid;
      end
   end

   assign load_en = !out_valid || out_ready;
   assign accept  = load_en && grant_valid && reset_n;

   always_comb begin
      in_ready   = '0;
      grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant == SELW'(i)) begin
            in_ready[i] = accept;
            grant_data  = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= SELW'(N - 1);
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= grant_data;
         out_ch    <= grant;
         if (mode == MODE_RR) begin
            ptr <= grant;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_n_to_one_mux.sv
// Directed bench for rr_n_to_one_mux: driver steps push expected words,
// a negedge monitor pops and compares every word the consumer takes.
module tb_rr_n_to_one_mux;

   localparam int WIDTH = 8;
   localparam int N     = 4;
   localparam int SELW  = 2;

   logic               clk = 1'b0;
   logic               reset_n;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic               mode;
   logic [SELW-1:0]    sel;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic [SELW-1:0]    out_ch;

   logic [SELW+WIDTH-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   rr_n_to_one_mux #(
      .WIDTH (WIDTH),
      .N     (N),
      .SELW  (SELW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: a word is consumed at the next posedge when
   // out_valid && out_ready are seen at the negedge.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", {22'd0, out_ch, out_data}, 32'hFFFF_FFFF);
         end else begin
            logic [SELW+WIDTH-1:0] e;
            e = exp_q.pop_front();
            check("out_ch", 32'(out_ch), 32'(e[SELW+WIDTH-1:WIDTH]));
            check("out_data", 32'(out_data), 32'(e[WIDTH-1:0]));
         end
      end
   end

   // Driver: apply one cycle of inputs at posedge+2, check in_ready, and queue
   // the hand-computed word expected to be accepted at the coming edge.
   task automatic step(input logic [N-1:0] vld, input logic md, input logic [SELW-1:0] sl,
                       input logic ordy, input logic [N-1:0] exp_rdy,
                       input logic [WIDTH-1:0] exp_d, input string name);
      logic [SELW-1:0] ch;
      in_valid  = vld;
      mode      = md;
      sel       = sl;
      out_ready = ordy;
      #1;
      check(name, 32'(in_ready), 32'(exp_rdy));
      if (exp_rdy != '0) begin
         ch = '0;
         for (int i = 0; i < N; i++) if (exp_rdy[i]) ch = SELW'(i);
         exp_q.push_back({ch, exp_d});
      end
      @(posedge clk);
      #2;
   endtask

   initial begin
      // 1. reset with everything active
      reset_n   = 1'b0;
      in_valid  = 4'b1111;
      in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
      mode      = 1'b0;
      sel       = '0;
      out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_ch", 32'(out_ch), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      reset_n = 1'b1;
      in_data = {8'h13, 8'hA5, 8'h11, 8'h10};
      step(4'b0100, 1'b0, 2'd0, 1'b1, 4'b0100, 8'hA5, "t1_grant2");
      check("t1_out_data", 32'(out_data), 32'hA5);
      check("t1_out_ch", 32'(out_ch), 32'd2);
      step(4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 8'h00, "t1_idle");
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      in_data = {8'h13, 8'h12, 8'h11, 8'h10};

      // 2. round-robin fairness, one word per cycle
      step(4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 8'h10, "t2_rr0");
      step(4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010, 8'h11, "t2_rr1");
      step(4'b1111, 1'b0, 2'd0, 1'b1, 4'b0100, 8'h12, "t2_rr2");
      step(4'b1111, 1'b0, 2'd0, 1'b1, 4'b1000, 8'h13, "t2_rr3");
      step(4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 8'h10, "t2_rr4");
      step(4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010, 8'h11, "t2_rr5");

      // 3. backpressure holds the word, then drain and load together
      for (int i = 0; i < 3; i++) begin
         step(4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00, "t3_stall_rdy");
         check("t3_stall_data", 32'(out_data), 32'h11);
         check("t3_stall_valid", 32'(out_valid), 32'd1);
      end
      step(4'b1111, 1'b0, 2'd0, 1'b1, 4'b0100, 8'h12, "t3_release");

      // 4. fixed select
      for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 2'd3, 1'b1, 4'b1000, 8'h13, "t4_sel3");
      for (int i = 0; i < 2; i++) step(4'b1111, 1'b1, 2'd1, 1'b1, 4'b0010, 8'h11, "t4_sel1");

      // 5. mode switch preserves ptr (ptr=2 here; lone ch1 moves it to 1)
      step(4'b0010, 1'b0, 2'd0, 1'b1, 4'b0010, 8'h11, "t5_rr1");
      step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h10, "t5_fix0a");
      step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h10, "t5_fix0b");
      step(4'b1111, 1'b0, 2'd0, 1'b1, 4'b0100, 8'h12, "t5_resume");

      // single requester is granted every cycle
      step(4'b0100, 1'b0, 2'd0, 1'b1, 4'b0100, 8'h12, "single_a");
      step(4'b0100, 1'b0, 2'd0, 1'b1, 4'b0100, 8'h12, "single_b");

      // 6. async reset between edges while a word is held
      step(4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00, "t6_hold");
      check("t6_pre_valid", 32'(out_valid), 32'd1);
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      reset_n   = 1'b0;
      #1;
      check("t6_rst_valid", 32'(out_valid), 32'd0);
      check("t6_rst_in_ready", 32'(in_ready), 32'd0);
      check("t6_rst_data", 32'(out_data), 32'd0);
      exp_q.delete();
      reset_n = 1'b1;
      step(4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 8'h10, "t6_first");
      check("t6_first_ch", 32'(out_ch), 32'd0);
      step(4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 8'h00, "t6_idle0");
      step(4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 8'h00, "t6_idle1");

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      check("final_out_valid", 32'(out_valid), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
